// File: rtl/keypad_display_rx_if.sv
// Key-strobe and display bus between the keypad front-end and the display receiver.
// The master drives key_valid/key_code; the slave (display receiver) drives everything else.
interface keypad_display_rx_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic [6:0] seg;
  logic       an0;
  logic       an1;
  logic       key_ack;
  logic [7:0] key_count;

  modport master (
    output key_valid, key_code,
    input  seg, an0, an1, key_ack, key_count
  );

  modport slave (
    input  key_valid, key_code,
    output seg, an0, an1, key_ack, key_count
  );
endinterface

// File: rtl/keypad_display_rx.sv
// Keeps the last two hex keys and multiplexes them onto a 2-digit active-low 7-seg display.
// A key is captured on the strobe edge and ack'd next cycle; there is no backpressure, so every strobe is taken.
module keypad_display_rx #(
  parameter int DWELL = 24000,
  parameter int GAP   = 240
) (
  input  logic                clk,
  input  logic                reset,
  keypad_display_rx_if.slave  bus
);

  typedef enum logic [1:0] {DIG0, GAP0, DIG1, GAP1} state_t;

  localparam int MAXLEN = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam bit HAS_GAP = (GAP > 0);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_last;

  logic [3:0]    r_latest;
  logic [3:0]    r_prev;
  logic          r_v_latest;
  logic          r_v_prev;
  logic          r_ack;
  logic [7:0]    r_count;

  logic [6:0]    w_seg;
  logic          w_an0;
  logic          w_an1;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= DIG0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // With no gap configured the GAPx states are unreachable; DIGx hands over directly.
  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    w_an0       = 1'b1;
    w_an1       = 1'b1;
    w_seg       = 7'h7F;
    case (r_state)
      DIG0: begin
        w_an0 = 1'b0;
        w_seg = r_v_latest ? hex7(r_latest) : 7'h7F;
        if (r_cnt == DW_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = HAS_GAP ? GAP0 : DIG1;
        end
      end
      GAP0: begin
        if (r_cnt == GP_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = DIG1;
        end
      end
      DIG1: begin
        w_an1 = 1'b0;
        w_seg = r_v_prev ? hex7(r_prev) : 7'h7F;
        if (r_cnt == DW_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = HAS_GAP ? GAP1 : DIG0;
        end
      end
      GAP1: begin
        if (r_cnt == GP_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = DIG0;
        end
      end
      default: begin
        w_last      = 1'b1;
        w_state_nxt = DIG0;
      end
    endcase
  end

  // Capture path runs free of the multiplexer: it never waits for or disturbs the scan.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_latest   <= 4'h0;
      r_prev     <= 4'h0;
      r_v_latest <= 1'b0;
      r_v_prev   <= 1'b0;
      r_ack      <= 1'b0;
      r_count    <= 8'h00;
    end else begin
      r_ack <= bus.key_valid;
      if (bus.key_valid) begin
        r_prev     <= r_latest;
        r_v_prev   <= r_v_latest;
        r_latest   <= bus.key_code;
        r_v_latest <= 1'b1;
        r_count    <= r_count + 8'd1;
      end
    end
  end

  assign bus.seg       = w_seg;
  assign bus.an0       = w_an0;
  assign bus.an1       = w_an1;
  assign bus.key_ack   = r_ack;
  assign bus.key_count = r_count;

endmodule

// File: tb/tb_keypad_display_rx.sv
// Directed bench: DUT a (DWELL=4, GAP=1) for function, DUT b (DWELL=3, GAP=0) for gapless scan.
module tb_keypad_display_rx;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  keypad_display_rx_if bus_a ();
  keypad_display_rx_if bus_b ();

  keypad_display_rx #(.DWELL(4), .GAP(1)) u_dut_a (.clk(clk), .reset(rst_n), .bus(bus_a.slave));
  keypad_display_rx #(.DWELL(3), .GAP(0)) u_dut_b (.clk(clk), .reset(rst_n), .bus(bus_b.slave));

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Advance to the first negedge where DUT a lights the requested digit (bounded).
  task automatic wait_a(input bit right_digit, input string tag);
    int n;
    n = 0;
    while (!(right_digit ? (bus_a.an0 === 1'b0) : (bus_a.an1 === 1'b0)) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_b(input bit right_digit, input string tag);
    int n;
    n = 0;
    while (!(right_digit ? (bus_b.an0 === 1'b0) : (bus_b.an1 === 1'b0)) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [8:0] exp_a;
    logic [8:0] exp_b;
    logic [3:0] b_lat, b_prev;
    logic       b_vl, b_vp;
    logic [7:0] b_cnt;
    int         both_low, both_high, m;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus_a.key_valid = 1'b0;  bus_a.key_code = 4'h0;
    bus_b.key_valid = 1'b0;  bus_b.key_code = 4'h0;
    repeat (3) @(negedge clk);

    chk("rst_disp", {23'd0, bus_a.an0, bus_a.an1, bus_a.seg}, {23'd0, 1'b0, 1'b1, 7'h7F});
    chk("rst_ack", {31'd0, bus_a.key_ack}, 32'd0);
    chk("rst_cnt", {24'd0, bus_a.key_count}, 32'd0);

    // Idle scan: a has period 10 (4 on, 1 off, 4 on, 1 off); b has period 6, no gap.
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      m = i % 10;
      if (m < 4)       exp_a = {1'b0, 1'b1, 7'h7F};
      else if (m < 5)  exp_a = {1'b1, 1'b1, 7'h7F};
      else if (m < 9)  exp_a = {1'b1, 1'b0, 7'h7F};
      else             exp_a = {1'b1, 1'b1, 7'h7F};
      chk($sformatf("scan_a%0d", i), {23'd0, bus_a.an0, bus_a.an1, bus_a.seg}, {23'd0, exp_a});
      exp_b = ((i % 6) < 3) ? {1'b0, 1'b1, 7'h7F} : {1'b1, 1'b0, 7'h7F};
      chk($sformatf("scan_b%0d", i), {23'd0, bus_b.an0, bus_b.an1, bus_b.seg}, {23'd0, exp_b});
      @(negedge clk);
    end

    // Single key 5 at start of DIG0.
    bus_a.key_valid = 1'b1;  bus_a.key_code = 4'h5;
    @(negedge clk);
    bus_a.key_valid = 1'b0;
    chk("k5_seg", {23'd0, bus_a.an0, bus_a.an1, bus_a.seg}, {23'd0, 1'b0, 1'b1, 7'h12});
    chk("k5_ack", {31'd0, bus_a.key_ack}, 32'd1);
    chk("k5_cnt", {24'd0, bus_a.key_count}, 32'd1);
    @(negedge clk);
    chk("k5_ack_drop", {31'd0, bus_a.key_ack}, 32'd0);
    wait_a(1'b0, "k5_dig1");
    chk("k5_prev_blank", {24'd0, bus_a.seg}, 32'h7F);

    // Back-to-back keys 1 then A.
    bus_a.key_valid = 1'b1;  bus_a.key_code = 4'h1;
    @(negedge clk);
    chk("b2b_ack1", {31'd0, bus_a.key_ack}, 32'd1);
    bus_a.key_code = 4'hA;
    @(negedge clk);
    bus_a.key_valid = 1'b0;
    chk("b2b_ack2", {31'd0, bus_a.key_ack}, 32'd1);
    @(negedge clk);
    chk("b2b_ack_drop", {31'd0, bus_a.key_ack}, 32'd0);
    chk("b2b_cnt", {24'd0, bus_a.key_count}, 32'd3);
    wait_a(1'b1, "b2b_dig0");
    chk("b2b_latest", {24'd0, bus_a.seg}, 32'h08);
    wait_a(1'b0, "b2b_dig1");
    chk("b2b_prev", {24'd0, bus_a.seg}, 32'h79);

    // Reset mid-DIG1 with a coincident strobe.
    bus_a.key_valid = 1'b1;  bus_a.key_code = 4'h7;
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_disp", {23'd0, bus_a.an0, bus_a.an1, bus_a.seg}, {23'd0, 1'b0, 1'b1, 7'h7F});
    chk("mrst_cnt", {24'd0, bus_a.key_count}, 32'd0);
    @(negedge clk);
    bus_a.key_valid = 1'b0;
    rst_n = 1'b1;
    chk("mrst_cnt_hold", {24'd0, bus_a.key_count}, 32'd0);
    @(negedge clk);
    chk("mrst_ack", {31'd0, bus_a.key_ack}, 32'd0);
    chk("mrst_dig0", {23'd0, bus_a.an0, bus_a.an1, bus_a.seg}, {23'd0, 1'b0, 1'b1, 7'h7F});
    wait_a(1'b0, "mrst_dig1");
    chk("mrst_prev_blank", {24'd0, bus_a.seg}, 32'h7F);
    wait_a(1'b1, "mrst_dig0b");
    chk("mrst_latest_blank", {24'd0, bus_a.seg}, 32'h7F);

    // 256 keys: count wraps to 0; last two codes are F (latest) and E (previous).
    for (int i = 0; i < 256; i++) begin
      bus_a.key_valid = 1'b1;
      bus_a.key_code  = 4'(i);
      @(negedge clk);
    end
    bus_a.key_valid = 1'b0;
    chk("wrap_cnt", {24'd0, bus_a.key_count}, 32'd0);
    wait_a(1'b1, "wrap_dig0");
    chk("wrap_latest", {24'd0, bus_a.seg}, 32'h0E);
    wait_a(1'b0, "wrap_dig1");
    chk("wrap_prev", {24'd0, bus_a.seg}, 32'h06);

    // Gapless DUT under random traffic: exactly one anode low every cycle.
    b_lat = 4'h0;  b_prev = 4'h0;  b_vl = 1'b0;  b_vp = 1'b0;  b_cnt = 8'd0;
    both_low = 0;  both_high = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus_b.an0 === 1'b0 && bus_b.an1 === 1'b0) both_low++;
      if (bus_b.an0 !== 1'b0 && bus_b.an1 !== 1'b0) both_high++;
      bus_b.key_valid = 1'($urandom_range(0, 1));
      bus_b.key_code  = 4'($urandom_range(0, 15));
      if (bus_b.key_valid) begin
        b_prev = b_lat;  b_vp = b_vl;
        b_lat  = bus_b.key_code;  b_vl = 1'b1;
        b_cnt  = b_cnt + 8'd1;
      end
      @(negedge clk);
    end
    bus_b.key_valid = 1'b0;
    chk("gap0_both_low", both_low, 32'd0);
    chk("gap0_both_high", both_high, 32'd0);
    chk("gap0_cnt", {24'd0, bus_b.key_count}, {24'd0, b_cnt});
    wait_b(1'b1, "gap0_dig0");
    chk("gap0_latest", {24'd0, bus_b.seg}, {24'd0, (b_vl ? hex_tab[b_lat] : 7'h7F)});
    wait_b(1'b0, "gap0_dig1");
    chk("gap0_prev", {24'd0, bus_b.seg}, {24'd0, (b_vp ? hex_tab[b_prev] : 7'h7F)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
